// File: rtl/pps_pkg.sv
// Shared constants and state encoding for the PPS period meter.
package pps_pkg;

  localparam int NOMINAL_CYCLES = 124502500;
  localparam int TOL_CYCLES     = 2500;
  localparam int MISS_COUNT_W   = 8;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } pps_state_t;

endpackage

// File: rtl/pps_sync_edge.sv
// Two-flop synchroniser for the async PPS pin plus a rising-edge detector.
// A pin level first sampled at edge k gives rise high during the cycle after edge k+1.
module pps_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pps_in,
  output logic rise
);

  logic sync0;
  logic sync1;
  logic sync1_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      sync1_d <= 1'b0;
    end else begin
      sync0   <= pps_in;
      sync1   <= sync0;
      sync1_d <= sync1;
    end
  end

  // Only the 0->1 transition counts, so a long high level yields a single pulse.
  assign rise = sync1 & ~sync1_d;

endmodule

// File: rtl/pps_period_meter.sv
// PPS period meter: counts clk cycles between PPS rising edges, flags in-tolerance/lock/missing; results registered two clks after the pin is sampled, no backpressure.
// Optional PPS_ERR_REPORT_EN adds signed period_err (period - NOMINAL) and a saturating miss_count.
module pps_period_meter
  import pps_pkg::*;
#(
  parameter int  NOMINAL    = NOMINAL_CYCLES,
  parameter int  TOL        = TOL_CYCLES,
  parameter int  LOCK_COUNT = 4,
  localparam int WIDTH      = $clog2(NOMINAL + TOL + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pps_in,
  output logic [WIDTH-1:0]        period,
  output logic                    period_valid,
  output logic                    in_tol,
  output logic                    locked,
  output logic                    missing
`ifdef PPS_ERR_REPORT_EN
  ,
  output logic [WIDTH:0]          period_err,
  output logic [MISS_COUNT_W-1:0] miss_count
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(NOMINAL + TOL);
  localparam logic [WIDTH-1:0] CNT_MIN  = WIDTH'(NOMINAL - TOL);
  localparam int               GW       = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    GOOD_SAT = GW'(LOCK_COUNT);

  pps_state_t       state_q;
  pps_state_t       state_d;
  logic             rise;
  logic [WIDTH-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic [GW-1:0]    good_inc;
  logic             tol_ok;
  logic             active;
  logic             hit;
  logic             timeout;

  pps_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pps_in (pps_in),
    .rise   (rise)
  );

  assign tol_ok   = (cnt >= CNT_MIN) && (cnt <= CNT_MAX);
  assign good_inc = (good_cnt == GOOD_SAT) ? GOOD_SAT : good_cnt + GW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // An edge arriving in the same cycle the count hits its ceiling wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          if (tol_ok && (good_inc == GOOD_SAT)) state_d = LOCKED;
        end else if (cnt == CNT_MAX) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!tol_ok) state_d = MEASURE;
        end else if (cnt == CNT_MAX) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    active  = (state_q != SEARCH);
    locked  = (state_q == LOCKED);
    hit     = active && rise;
    timeout = active && !rise && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt <= '0;
    else if (rise)               cnt <= WIDTH'(1);
    else if (!active || timeout) cnt <= '0;
    else                         cnt <= cnt + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      missing      <= 1'b0;
      good_cnt     <= '0;
    end else begin
      period_valid <= hit;
      missing      <= timeout;
      if (hit) begin
        period   <= cnt;
        in_tol   <= tol_ok;
        good_cnt <= tol_ok ? good_inc : '0;
      end else if (timeout) begin
        good_cnt <= '0;
      end
    end
  end

`ifdef PPS_ERR_REPORT_EN
  localparam logic [WIDTH:0] NOM_EXT = (WIDTH + 1)'(NOMINAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_err <= '0;
      miss_count <= '0;
    end else begin
      if (hit) period_err <= {1'b0, cnt} - NOM_EXT;
      if (timeout && (miss_count != '1)) miss_count <= miss_count + MISS_COUNT_W'(1);
    end
  end
`endif

endmodule
